// File: rtl/delta_event_pkg.sv
// delta_event_pkg: shared widths, polarity and mode constants for the delta event encoder
package delta_event_pkg;
  localparam logic POL_ON = 1'b1;
  localparam logic POL_OFF = 1'b0;
  localparam logic MODE_LATCH = 1'b0;
  localparam logic MODE_STEP = 1'b1;
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int lvl_w(input int d);
    return $clog2(d) + 1;
  endfunction
endpackage

// File: rtl/event_fifo.sv
// event_fifo: show-ahead FIFO, no empty bypass; push_i/data_i in, pop_i/data_o/valid_o out, full_o, level_o
module event_fifo
  import delta_event_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LVL_W = lvl_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             full_o,
  output logic [LVL_W-1:0] level_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [LVL_W-1:0] lvl_q;
  always_ff @(posedge clk)
    if (push_i) mem_q[wr_q] <= data_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      lvl_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(push_i);
      rd_q <= rd_q + AW'(pop_i);
      lvl_q <= lvl_q + LVL_W'(push_i) - LVL_W'(pop_i);
    end
  assign valid_o = lvl_q != '0;
  assign full_o = lvl_q == LVL_W'(DEPTH);
  assign level_o = lvl_q;
  // head is forced to zero when empty so outputs read 0 after reset
  assign data_o = valid_o ? mem_q[rd_q] : '0;
endmodule

// File: rtl/delta_event_encoder.sv
// delta_event_encoder: per-channel delta modulator, round-robin arbitrated into an event FIFO
// inputs: sample_valid/sample_data, thr_on/thr_off (0 disables), refrac_cycles, mode, clear_ovf, evt_ready
// outputs: evt_valid/evt_pol/evt_chan (FIFO head), fifo_level, overflow (sticky drop flag)
module delta_event_encoder
  import delta_event_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_CH = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int REFRAC_W = 4,
  localparam int CH_W = ch_w(N_CH),
  localparam int LVL_W = lvl_w(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_valid,
  input  logic [N_CH*WIDTH-1:0] sample_data,
  input  logic [WIDTH-1:0]      thr_on,
  input  logic [WIDTH-1:0]      thr_off,
  input  logic [REFRAC_W-1:0]   refrac_cycles,
  input  logic                  mode,
  input  logic                  clear_ovf,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic                  evt_pol,
  output logic [CH_W-1:0]       evt_chan,
  output logic [LVL_W-1:0]      fifo_level,
  output logic                  overflow
);
  logic [WIDTH-1:0] ref_q [N_CH];
  logic [WIDTH-1:0] ref_d [N_CH];
  logic [REFRAC_W-1:0] refr_q [N_CH];
  logic [REFRAC_W-1:0] refr_d [N_CH];
  logic [N_CH-1:0] pend_q, pend_d, pol_q, pol_d, fire, drop;
  logic [CH_W-1:0] rr_q, rr_d, gnt_ch;
  logic ovf_q, gnt, full, pop;
  assign pop = evt_valid & evt_ready;
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [WIDTH-1:0] s;
    logic [WIDTH:0] up;
    logic signed [WIDTH:0] err;
    logic on, off, hit;
    assign s = sample_data[c*WIDTH +: WIDTH];
    assign err = $signed({1'b0, s}) - $signed({1'b0, ref_q[c]});
    assign on = (thr_on != '0) && (err >= $signed({1'b0, thr_on}));
    assign off = (thr_off != '0) && (err <= -$signed({1'b0, thr_off}));
    assign up = {1'b0, ref_q[c]} + {1'b0, thr_on};
    assign hit = sample_valid && (refr_q[c] == '0) && (on || off);
    assign fire[c] = hit && !pend_q[c];
    assign drop[c] = hit && pend_q[c];
    // grant sees the old pending bit; a fresh fire can only land on a cleared channel
    assign pend_d[c] = fire[c] | (pend_q[c] & ~(gnt && gnt_ch == CH_W'(c)));
    assign pol_d[c] = fire[c] ? (on ? POL_ON : POL_OFF) : pol_q[c];
    assign refr_d[c] = fire[c] ? refrac_cycles : (refr_q[c] != '0) ? refr_q[c] - 1'b1 : refr_q[c];
    assign ref_d[c] = !fire[c] ? ref_q[c] :
                      (mode == MODE_LATCH) ? s :
                      on ? (up[WIDTH] ? '1 : up[WIDTH-1:0]) :
                      (ref_q[c] > thr_off) ? ref_q[c] - thr_off : '0;
  end
  // lowest offset from the RR pointer wins, so iterate downwards and let later hits override
  always_comb begin
    gnt = 1'b0;
    gnt_ch = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (pend_q[CH_W'((int'(rr_q) + i) % N_CH)] && (!full || pop)) begin
        gnt = 1'b1;
        gnt_ch = CH_W'((int'(rr_q) + i) % N_CH);
      end
  end
  assign rr_d = !gnt ? rr_q : (gnt_ch == CH_W'(N_CH - 1)) ? '0 : gnt_ch + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ref_q <= '{default: '0};
      refr_q <= '{default: '0};
      pend_q <= '0;
      pol_q <= '0;
      rr_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      ref_q <= ref_d;
      refr_q <= refr_d;
      pend_q <= pend_d;
      pol_q <= pol_d;
      rr_q <= rr_d;
      ovf_q <= (|drop) | (ovf_q & ~clear_ovf);
    end
  assign overflow = ovf_q;
  event_fifo #(.WIDTH(1 + CH_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push_i(gnt),
    .data_i({pol_q[gnt_ch], gnt_ch}),
    .pop_i(pop),
    .data_o({evt_pol, evt_chan}),
    .valid_o(evt_valid),
    .full_o(full),
    .level_o(fifo_level)
  );
endmodule

// File: tb/tb_delta_event_encoder.sv
// tb_delta_event_encoder: directed vector table plus hand sequences for the delta event encoder
module tb_delta_event_encoder;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic sample_valid = 1'b0;
  logic [31:0] sample_data = '0;
  logic [7:0] thr_on = 8'd10;
  logic [7:0] thr_off = 8'd10;
  logic [3:0] refrac_cycles = '0;
  logic mode = 1'b0;
  logic clear_ovf = 1'b0;
  logic evt_ready = 1'b0;
  logic evt_valid, evt_pol, overflow;
  logic [1:0] evt_chan;
  logic [3:0] fifo_level;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int base = 0;
  typedef struct {int t; int pol; int ch;} ev_t;
  ev_t log_q[$];
  typedef struct {int sv; logic [31:0] data; int rdy; int ton; int toff; int ev; int ep; int ec; int el;} vec_t;
  vec_t tbl[20];
  delta_event_encoder dut (
    .clk(clk),
    .rst_n(rst_n),
    .sample_valid(sample_valid),
    .sample_data(sample_data),
    .thr_on(thr_on),
    .thr_off(thr_off),
    .refrac_cycles(refrac_cycles),
    .mode(mode),
    .clear_ovf(clear_ovf),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_pol(evt_pol),
    .evt_chan(evt_chan),
    .fifo_level(fifo_level),
    .overflow(overflow)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (rst_n && evt_valid && evt_ready) log_q.push_back('{cyc, int'(evt_pol), int'(evt_chan)});
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) step();
  endtask
  task automatic pulse(input logic [31:0] d);
    sample_valid = 1'b1;
    sample_data = d;
    step();
    sample_valid = 1'b0;
  endtask
  task automatic outs(input string tag, input int v, input int p, input int c, input int l, input int o);
    chk({tag, ".valid"}, int'(evt_valid), v);
    chk({tag, ".pol"}, int'(evt_pol), p);
    chk({tag, ".chan"}, int'(evt_chan), c);
    chk({tag, ".level"}, int'(fifo_level), l);
    chk({tag, ".ovf"}, int'(overflow), o);
  endtask
  task automatic ev_chk(input string tag, input int idx, input int p, input int c);
    if (idx < log_q.size()) begin
      chk({tag, ".pol"}, log_q[idx].pol, p);
      chk({tag, ".chan"}, log_q[idx].ch, c);
    end else chk({tag, ".missing"}, -1, c);
  endtask
  initial begin
    // columns: sv, data, ready, thr_on, thr_off | exp valid, pol, chan, level (after the edge)
    tbl = '{
      '{1, 32'h000F0000, 0, 10, 10, 0, 0, 0, 0},
      '{0, 32'h000F0000, 0, 10, 10, 1, 1, 2, 1},
      '{0, 32'h000F0000, 0, 10, 10, 1, 1, 2, 1},
      '{0, 32'h000F0000, 1, 10, 10, 0, 0, 0, 0},
      '{1, 32'h00060000, 0, 10, 10, 0, 0, 0, 0},
      '{0, 32'h00060000, 0, 10, 10, 0, 0, 0, 0},
      '{1, 32'h00050000, 0, 10, 10, 0, 0, 0, 0},
      '{0, 32'h00050000, 0, 10, 10, 1, 0, 2, 1},
      '{0, 32'h00050000, 1, 10, 10, 0, 0, 0, 0},
      '{1, 32'hC8050000, 0, 0, 10, 0, 0, 0, 0},
      '{0, 32'hC8050000, 0, 0, 10, 0, 0, 0, 0},
      '{1, 32'h00050000, 0, 0, 10, 0, 0, 0, 0},
      '{0, 32'h00050000, 0, 0, 10, 0, 0, 0, 0},
      '{1, 32'h00000000, 0, 10, 0, 0, 0, 0, 0},
      '{0, 32'h00000000, 0, 10, 0, 0, 0, 0, 0},
      '{1, 32'h09050000, 0, 10, 10, 0, 0, 0, 0},
      '{0, 32'h09050000, 0, 10, 10, 0, 0, 0, 0},
      '{1, 32'h0A050000, 0, 10, 10, 0, 0, 0, 0},
      '{0, 32'h0A050000, 0, 10, 10, 1, 1, 3, 1},
      '{0, 32'h0A050000, 1, 10, 10, 0, 0, 0, 0}
    };
    #2 rst_n = 1'b0;
    #1 outs("reset", 0, 0, 0, 0, 0);
    idle(2);
    rst_n = 1'b1;
    // latch mode single-channel events, threshold boundaries and disabled thresholds
    for (int i = 0; i < 20; i++) begin
      sample_valid = tbl[i].sv != 0;
      sample_data = tbl[i].data;
      evt_ready = tbl[i].rdy != 0;
      thr_on = 8'(tbl[i].ton);
      thr_off = 8'(tbl[i].toff);
      step();
      outs($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ep, tbl[i].ec, tbl[i].el, 0);
    end
    sample_valid = 1'b0;
    // STEP mode: ch0 climbs 0->10->20->30 toward 35, then steps back down to 0
    mode = 1'b1;
    evt_ready = 1'b1;
    base = log_q.size();
    for (int k = 0; k < 4; k++) begin
      pulse(32'h0A050023);
      idle(3);
    end
    chk("step_on.count", log_q.size() - base, 3);
    for (int j = 0; j < 3; j++) ev_chk($sformatf("step_on%0d", j), base + j, 1, 0);
    base = log_q.size();
    for (int k = 0; k < 4; k++) begin
      pulse(32'h0A050000);
      idle(3);
    end
    chk("step_off.count", log_q.size() - base, 3);
    for (int j = 0; j < 3; j++) ev_chk($sformatf("step_off%0d", j), base + j, 0, 0);
    // refractory: fires at edges 0,7,14; edge 6 is eligible but sees a sample equal to the latched ref
    mode = 1'b0;
    refrac_cycles = 4'd5;
    base = log_q.size();
    for (int j = 0; j < 21; j++) begin
      sample_valid = 1'b1;
      sample_data = (j % 2 == 0) ? 32'h0A053200 : 32'h0A050000;
      step();
    end
    sample_valid = 1'b0;
    idle(6);
    refrac_cycles = '0;
    chk("refrac.count", log_q.size() - base, 3);
    ev_chk("refrac0", base, 1, 1);
    ev_chk("refrac1", base + 1, 0, 1);
    ev_chk("refrac2", base + 2, 1, 1);
    if (log_q.size() - base >= 3) begin
      chk("refrac.gap1", log_q[base + 1].t - log_q[base].t, 7);
      chk("refrac.gap2", log_q[base + 2].t - log_q[base + 1].t, 7);
    end
    // async reset mid-burst with events queued and overflow set
    evt_ready = 1'b0;
    pulse(32'h64646464);
    idle(4);
    pulse(32'h00000000);
    pulse(32'h64646464);
    chk("prerst.level", int'(fifo_level), 5);
    chk("prerst.ovf", int'(overflow), 1);
    #2 rst_n = 1'b0;
    #1 outs("midrst", 0, 0, 0, 0, 0);
    idle(2);
    rst_n = 1'b1;
    evt_ready = 1'b1;
    base = log_q.size();
    idle(6);
    chk("postrst.events", log_q.size() - base, 0);
    outs("postrst", 0, 0, 0, 0, 0);
    // fill to full, then drop into a pending channel
    evt_ready = 1'b0;
    pulse(32'h64646464);
    idle(4);
    chk("fill.level4", int'(fifo_level), 4);
    pulse(32'h00000000);
    idle(4);
    outs("full", 1, 1, 0, 8, 0);
    pulse(32'h64646464);
    outs("full_pend", 1, 1, 0, 8, 0);
    pulse(32'h00000000);
    outs("drop", 1, 1, 0, 8, 1);
    idle(2);
    outs("hold", 1, 1, 0, 8, 1);
    clear_ovf = 1'b1;
    pulse(32'h00000000);
    chk("clr_vs_drop.ovf", int'(overflow), 1);
    step();
    clear_ovf = 1'b0;
    chk("clr.ovf", int'(overflow), 0);
    evt_ready = 1'b1;
    base = log_q.size();
    for (int k = 0; k < 60 && log_q.size() - base < 12; k++) step();
    idle(2);
    chk("drain.count", log_q.size() - base, 12);
    for (int j = 0; j < 12; j++) ev_chk($sformatf("drain%0d", j), base + j, (j / 4 == 1) ? 0 : 1, j % 4);
    outs("drained", 0, 0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
